// File: rtl/acia_6850_link.sv
// rtl/acia_6850_link.sv - 6850-style ACIA link, fixed 8N1 framing, host register port and serial RX/TX.
// Defining ACIA_RX_FIFO_EN replaces the single RDR with an RX_FIFO_DEPTH-entry receive FIFO.
module acia_6850_link #(
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       mcu_clx2,
  input  logic       mcu_rst_n,
  input  logic       baud_en,
  input  logic       cpu_sel,
  input  logic       cpu_rs,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       irq_n,
  input  logic       rxd,
  output logic       txd
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  rx_state_e  rx_st_q, rx_st_d;
  tx_state_e  tx_st_q, tx_st_d;
  logic [7:0] cr_q, cr_d, tdr_q, tdr_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [5:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic       rx_s1_q, rx_s2_q, rx_s3_q;
  logic       tdre_q, tdre_d, txd_q, txd_d, fe_q, fe_d, ovrn_q, ovrn_d, last_stat_q, last_stat_d;
  logic       rx_done, rx_chk, tx_load, rx_full, rx_avail, irq;
  logic [7:0] rx_head;
  logic       n_is_one;
  logic [5:0] n_m1, half_m1;

  logic cr_wr, td_wr, stat_rd, data_rd, blk_rst;
  assign cr_wr   = cpu_sel & ~cpu_rs & ~cpu_rw;
  assign stat_rd = cpu_sel & ~cpu_rs &  cpu_rw;
  assign td_wr   = cpu_sel &  cpu_rs & ~cpu_rw;
  assign data_rd = cpu_sel &  cpu_rs &  cpu_rw;
  // Master reset holds everything but CR cleared, including on the edge that writes it.
  assign blk_rst = (cr_q[1:0] == 2'b11) | (cr_wr & (cpu_din[1:0] == 2'b11));
  assign cr_d        = cr_wr ? cpu_din : cr_q;
  assign last_stat_d = cpu_sel ? stat_rd : last_stat_q;

  always_comb begin
    n_is_one = 1'b0;
    n_m1     = 6'd15;
    half_m1  = 6'd7;
    case (cr_q[1:0])
      2'b00:   begin n_is_one = 1'b1; n_m1 = 6'd0; half_m1 = 6'd0; end
      2'b10:   begin n_m1 = 6'd63; half_m1 = 6'd31; end
      default: ;
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    rx_chk   = 1'b0;
    case (rx_st_q)
      R_IDLE: if (rx_s3_q & ~rx_s2_q) begin rx_st_d = R_START; rx_cnt_d = '0; end
      R_START: begin
        if (n_is_one) rx_chk = 1'b1;
        else if (baud_en) begin
          if (rx_cnt_q == half_m1) rx_chk = 1'b1;
          else rx_cnt_d = rx_cnt_q + 6'd1;
        end
        if (rx_chk) begin
          rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
          rx_cnt_d = '0;
          rx_bit_d = '0;
        end
      end
      R_DATA: if (baud_en) begin
        if (rx_cnt_q == n_m1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
        end else rx_cnt_d = rx_cnt_q + 6'd1;
      end
      R_STOP: if (baud_en) begin
        if (rx_cnt_q == n_m1) begin
          rx_done  = 1'b1;
          rx_st_d  = R_IDLE;
          rx_cnt_d = '0;
        end else rx_cnt_d = rx_cnt_q + 6'd1;
      end
      default: rx_st_d = R_IDLE;
    endcase
    if (blk_rst) begin
      rx_st_d  = R_IDLE;
      rx_cnt_d = '0;
      rx_bit_d = '0;
      rx_done  = 1'b0;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tdr_d    = tdr_q;
    tdre_d   = tdre_q;
    tx_load  = 1'b0;
    case (tx_st_q)
      T_IDLE: begin txd_d = 1'b1; tx_load = ~tdre_q; end
      T_START: if (baud_en) begin
        if (tx_cnt_q == n_m1) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          txd_d    = tx_sh_q[0];
          tx_st_d  = T_DATA;
        end else tx_cnt_d = tx_cnt_q + 6'd1;
      end
      T_DATA: if (baud_en) begin
        if (tx_cnt_q == n_m1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = T_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 6'd1;
      end
      T_STOP: if (baud_en) begin
        if (tx_cnt_q == n_m1) begin
          if (tdre_q) tx_st_d = T_IDLE;
          else tx_load = 1'b1;
        end else tx_cnt_d = tx_cnt_q + 6'd1;
      end
      default: tx_st_d = T_IDLE;
    endcase
    // A held TDR write chains straight from the stop bit into the next start bit.
    if (tx_load) begin
      tx_sh_d  = tdr_q;
      tdre_d   = 1'b1;
      txd_d    = 1'b0;
      tx_cnt_d = '0;
      tx_st_d  = T_START;
    end
    if (td_wr) begin tdr_d = cpu_din; tdre_d = 1'b0; end
    if (blk_rst) begin
      tx_st_d  = T_IDLE;
      tx_cnt_d = '0;
      tx_bit_d = '0;
      txd_d    = 1'b1;
      tdr_d    = '0;
      tdre_d   = 1'b1;
    end
  end

  always_comb begin
    fe_d = fe_q;
    if (data_rd) fe_d = 1'b0;
    if (rx_done & ~rx_s2_q) fe_d = 1'b1;
    ovrn_d = ovrn_q;
    if (data_rd & last_stat_q) ovrn_d = 1'b0;
    if (rx_done & rx_full) ovrn_d = 1'b1;
    if (blk_rst) begin fe_d = 1'b0; ovrn_d = 1'b0; end
  end

`ifdef ACIA_RX_FIFO_EN
  localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(RX_FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  logic [7:0]    fifo_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    rdr_q, rdr_d;
  logic          push, pop;

  assign rx_full  = (cnt_q == DEPTH_C);
  assign rx_avail = (cnt_q != '0);
  assign rx_head  = rx_avail ? fifo_q[rp_q] : rdr_q;
  assign push     = rx_done & ~rx_full;
  assign pop      = data_rd & rx_avail;

  always_comb begin
    wp_d  = push ? wp_q + PTR_ONE : wp_q;
    rp_d  = pop ? rp_q + PTR_ONE : rp_q;
    rdr_d = pop ? fifo_q[rp_q] : rdr_q;
    cnt_d = cnt_q;
    if (push & ~pop) cnt_d = cnt_q + CNT_ONE;
    if (pop & ~push) cnt_d = cnt_q - CNT_ONE;
    if (blk_rst) begin wp_d = '0; rp_d = '0; cnt_d = '0; rdr_d = '0; end
  end

  always_ff @(posedge mcu_clx2) if (push) fifo_q[wp_q] <= rx_sh_q;

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      wp_q <= '0; rp_q <= '0; cnt_q <= '0; rdr_q <= '0;
    end else begin
      wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d; rdr_q <= rdr_d;
    end
  end
`else
  logic       rdrf_q, rdrf_d;
  logic [7:0] rdr_q, rdr_d;

  assign rx_full  = rdrf_q;
  assign rx_avail = rdrf_q;
  assign rx_head  = rdr_q;

  always_comb begin
    rdrf_d = rdrf_q;
    rdr_d  = rdr_q;
    if (data_rd) rdrf_d = 1'b0;
    if (rx_done & ~rdrf_q) begin rdrf_d = 1'b1; rdr_d = rx_sh_q; end
    if (blk_rst) begin rdrf_d = 1'b0; rdr_d = '0; end
  end

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin rdrf_q <= 1'b0; rdr_q <= '0; end
    else begin rdrf_q <= rdrf_d; rdr_q <= rdr_d; end
  end
`endif

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      cr_q <= 8'h03; last_stat_q <= 1'b0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
      rx_st_q <= R_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      tx_st_q <= T_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
      tdr_q <= '0; tdre_q <= 1'b1; txd_q <= 1'b1; fe_q <= 1'b0; ovrn_q <= 1'b0;
    end else begin
      cr_q <= cr_d; last_stat_q <= last_stat_d;
      rx_s1_q <= rxd; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      tdr_q <= tdr_d; tdre_q <= tdre_d; txd_q <= txd_d; fe_q <= fe_d; ovrn_q <= ovrn_d;
    end
  end

  assign irq      = (cr_q[7] & (rx_avail | ovrn_q)) | ((cr_q[6:5] == 2'b01) & tdre_q);
  assign irq_n    = ~irq;
  assign cpu_dout = cpu_rs ? rx_head : {irq, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rx_avail};
  assign txd      = txd_q;
endmodule

// File: tb/tb_acia_6850_link.sv
// tb/tb_acia_6850_link.sv - directed self-checking bench for acia_6850_link at /16, baud_en every 4 clocks.
module tb_acia_6850_link;
  logic       clk = 1'b0, rst_n = 1'b0, baud_en = 1'b0;
  logic       sel = 1'b0, rs = 1'b0, rw = 1'b1, rxd = 1'b1;
  logic [7:0] din = 8'h00, v;
  logic [7:0] dout;
  logic       irq_n, txd;
  logic [19:0] exp_bits;
  int n_cmp = 0, n_bad = 0, bcnt = 0;

  acia_6850_link dut (
    .mcu_clx2(clk), .mcu_rst_n(rst_n), .baud_en(baud_en), .cpu_sel(sel), .cpu_rs(rs),
    .cpu_rw(rw), .cpu_din(din), .cpu_dout(dout), .irq_n(irq_n), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    bcnt = bcnt + 1;
    baud_en = (bcnt % 4 == 0);
  end

  task automatic wr(input logic r, input logic [7:0] d);
    @(negedge clk); sel = 1'b1; rs = r; rw = 1'b0; din = d;
    @(negedge clk); sel = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic r, output logic [7:0] d);
    @(negedge clk); sel = 1'b1; rs = r; rw = 1'b1;
    #1 d = dout;
    @(negedge clk); sel = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (64) @(negedge clk); end
    rxd = stop;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL rst_txd got %b want 1", txd); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL rst_irq_n got %b want 1", irq_n); end
    rs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL rst_status got %h want 02", dout); end
    rs = 1'b1; #1;
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rst_rdr got %h want 00", dout); end
    @(negedge clk) rst_n = 1'b1;
    wr(1'b1, 8'h00);
    repeat (40) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL no_tx_before_cr got %b want 1", txd); end
    rs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL cr03_status got %h want 02", dout); end
  endtask

  task automatic test_tx;
    wr(1'b0, 8'h95);
    wr(1'b1, 8'hA5);
    rs = 1'b0; #1;
    n_cmp++; if (dout[1] !== 1'b0) begin n_bad++; $display("FAIL tdre_after_write got %b want 0", dout[1]); end
    @(negedge clk); #1;
    n_cmp++; if (dout[1] !== 1'b1) begin n_bad++; $display("FAIL tdre_after_load got %b want 1", dout[1]); end
    exp_bits = {10'h000, 1'b1, 8'hA5, 1'b0};
    repeat (32) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (txd !== exp_bits[i]) begin n_bad++; $display("FAIL tx_bit%0d got %b want %b", i, txd, exp_bits[i]); end
      repeat (64) @(negedge clk);
    end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL tx_irq_n got %b want 1", irq_n); end
  endtask

  task automatic test_back_to_back;
    wr(1'b1, 8'h81);
    for (int k = 0; k < 8 && txd !== 1'b0; k++) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL b2b_start_timeout got %b want 0", txd); end
    exp_bits = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h81, 1'b0};
    repeat (32) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (txd !== exp_bits[i]) begin n_bad++; $display("FAIL b2b_bit%0d got %b want %b", i, txd, exp_bits[i]); end
      if (i == 2) begin wr(1'b1, 8'h0F); repeat (62) @(negedge clk); end
      else repeat (64) @(negedge clk);
    end
  endtask

  task automatic test_rx;
    send(8'h3C, 1'b1);
    rs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h83) begin n_bad++; $display("FAIL rx_status got %h want 83", dout); end
    n_cmp++; if (irq_n !== 1'b0) begin n_bad++; $display("FAIL rx_irq_n got %b want 0", irq_n); end
    rd(1'b1, v);
    n_cmp++; if (v !== 8'h3C) begin n_bad++; $display("FAIL rx_data got %h want 3c", v); end
    rs = 1'b0; #1;
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL rx_irq_clr got %b want 1", irq_n); end
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL rx_status_clr got %h want 02", dout); end
  endtask

  task automatic test_overrun;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wr(1'b0, 8'h95);
    rd(1'b1, v);
    n_cmp++; if (v !== 8'h11) begin n_bad++; $display("FAIL ovr_first got %h want 11", v); end
`ifdef ACIA_RX_FIFO_EN
    rd(1'b1, v);
    n_cmp++; if (v !== 8'h22) begin n_bad++; $display("FAIL fifo_second got %h want 22", v); end
    rd(1'b0, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL fifo_status got %h want 02", v); end
`else
    rd(1'b0, v);
    n_cmp++; if (v !== 8'hA2) begin n_bad++; $display("FAIL ovr_status got %h want a2", v); end
    rd(1'b1, v);
    n_cmp++; if (v !== 8'h11) begin n_bad++; $display("FAIL ovr_rdr_kept got %h want 11", v); end
    rd(1'b0, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL ovr_cleared got %h want 02", v); end
`endif
  endtask

  task automatic test_frame_error;
    send(8'h7E, 1'b0);
    rs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h93) begin n_bad++; $display("FAIL fe_status got %h want 93", dout); end
    rd(1'b1, v);
    n_cmp++; if (v !== 8'h7E) begin n_bad++; $display("FAIL fe_data got %h want 7e", v); end
    rs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL fe_cleared got %h want 02", dout); end
  endtask

  task automatic test_glitch;
    @(negedge clk) rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    rs = 1'b0; #1;
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL glitch_status got %h want 02", dout); end
    send(8'h5A, 1'b1);
    rd(1'b1, v);
    n_cmp++; if (v !== 8'h5A) begin n_bad++; $display("FAIL post_glitch_data got %h want 5a", v); end
  endtask

  task automatic test_master_reset;
    send(8'h33, 1'b1);
    wr(1'b1, 8'h00);
    repeat (100) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL mr_mid_frame got %b want 0", txd); end
    wr(1'b0, 8'h03);
    rs = 1'b0; #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mr_txd got %b want 1", txd); end
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL mr_status got %h want 02", dout); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL mr_irq_n got %b want 1", irq_n); end
    rs = 1'b1; #1;
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL mr_rdr got %h want 00", dout); end
    wr(1'b1, 8'h00);
    repeat (100) @(negedge clk);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mr_inactive_txd got %b want 1", txd); end
    wr(1'b0, 8'h95);
  endtask

  task automatic test_async_reset;
    wr(1'b1, 8'h00);
    repeat (100) @(negedge clk);
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL ar_mid_frame got %b want 0", txd); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    rs = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL ar_txd got %b want 1", txd); end
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL ar_status got %h want 02", dout); end
    n_cmp++; if (irq_n !== 1'b1) begin n_bad++; $display("FAIL ar_irq_n got %b want 1", irq_n); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_tx;
    test_back_to_back;
    test_rx;
    test_overrun;
    test_frame_error;
    test_glitch;
    test_master_reset;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/acia_6850_link.md
ACIA_6850_LINK -- requirements
Module: acia_6850_link

Interface
REQ-001 Parameter RX_FIFO_DEPTH, default 4; receive FIFO entries, power of two, used only when ACIA_RX_FIFO_EN is defined.
REQ-002 mcu_clx2  in  1  single system clock; all state changes on its rising edge.
REQ-003 mcu_rst_n  in  1  asynchronous, active-low reset.
REQ-004 baud_en  in  1  one-clock pulse at the serial sample rate (16x the nominal 7812.5 bit/s link).
REQ-005 cpu_sel  in  1  host access strobe; high exactly one clock per access.
REQ-006 cpu_rs  in  1  register select: 0 = control/status, 1 = TDR/RDR.
REQ-007 cpu_rw  in  1  1 = read, 0 = write.
REQ-008 cpu_din  in  8  host write data.
REQ-009 cpu_dout  out  8  host read data; combinational from cpu_rs.
REQ-010 irq_n  out  1  active-low interrupt request.
REQ-011 rxd  in  1  serial input from the keyboard MCU SCI transmit pin.
REQ-012 txd  out  1  serial output to the keyboard MCU SCI receive pin; idle high.

Function
REQ-013 Control register CR is write-only: CR[1:0] = divide (00 /1, 01 /16, 10 /64, 11 master reset); CR[4:2] is stored, ignored, and the frame is always 8N1; CR[6:5] = 01 enables the TX interrupt; CR[7] enables the RX interrupt.
REQ-014 Status read returns {IRQ, 0 (PE), OVRN, FE, 0 (CTS), 0 (DCD), TDRE, RDRF}.
REQ-015 A data read returns RDR (FIFO head when enabled) and clears RDRF on the clock edge ending the access.
REQ-016 OVRN clears only on a data read whose preceding host access was a status read.
REQ-017 FE clears on any data read.
REQ-018 A data write loads TDR and clears TDRE.
REQ-019 Writing a value with CR[1:0] = 11 is a master reset, identical in effect to REQ-034 except that CR holds the written value; the block remains inactive while CR[1:0] = 11.
REQ-020 rxd is synchronised through two flops before any use.
REQ-021 Bit period N = 1, 16 or 64 baud_en pulses for divide /1, /16 or /64.
REQ-022 RX FSM states are R_IDLE, R_START, R_DATA and R_STOP.
REQ-023 R_IDLE -> R_START on a synchronised falling edge of rxd.
REQ-024 In R_START the line is rechecked after N/2 pulses (immediately when N = 1); if rxd is high, this is a false start and the FSM returns to R_IDLE with no flag set.
REQ-025 In R_DATA, 8 bits are sampled LSB first, one every N pulses.
REQ-026 In R_STOP the stop bit is sampled; the FSM then returns to R_IDLE.
REQ-027 Stop bit = 0: FE is set and the byte is still delivered.
REQ-028 Byte delivery with RDRF = 0 (or FIFO not full): the byte is stored and RDRF is set in the same clock as the stop-bit sample.
REQ-029 Byte delivery with RDRF = 1 (or FIFO full): the new byte is discarded, OVRN is set, and stored data is unchanged.
REQ-030 TX FSM states are T_IDLE, T_START, T_DATA and T_STOP; each bit lasts N pulses.
REQ-031 In T_IDLE with TDRE = 0: TDR is copied to the shift register, TDRE is set, txd = 0, and the FSM enters T_START within one clock.
REQ-032 A TDR write during T_DATA or T_STOP is held; its frame starts immediately after the current stop bit, with no idle gap.
REQ-033 irq_n = ~((CR[7] & (RDRF | OVRN)) | (CR[6:5] == 01 & TDRE)); the status IRQ bit equals ~irq_n.

Reset
REQ-034 While mcu_rst_n = 0: CR = 0x03, RDR = 0x00, FIFO empty, RDRF = 0, OVRN = 0, FE = 0, TDRE = 1, both FSMs idle, txd = 1, irq_n = 1, cpu_dout = 0x02 for cpu_rs = 0.
REQ-035 A reset during a frame aborts it immediately; txd returns to 1 asynchronously.
REQ-036 The first transmit after reset requires a CR write with CR[1:0] != 11.

Configuration
REQ-037 Macro ACIA_RX_FIFO_EN.
REQ-038 Defined: received bytes enter an RX_FIFO_DEPTH-entry FIFO; RDRF = FIFO not empty; OVRN is set only on arrival when the FIFO is full; a data read pops one entry; a read of an empty FIFO returns the last popped byte.
REQ-039 Not defined: single RDR behaviour per REQ-015 and REQ-028/029; RX_FIFO_DEPTH is ignored.

Verification
REQ-040 Reset, then write CR = 0x95, write TDR = 0xA5 -> txd at 16 pulses per bit shows 0,1,0,1,0,0,1,0,1,1; TDRE = 0 one clock after the write and 1 one clock after the write plus the frame load, then irq_n stays high (CR[6:5] = 00).
REQ-041 CR = 0x95, 0x3C sent on rxd -> RDRF = 1 and irq_n = 0 on the stop-sample clock; data read returns 0x3C, RDRF = 0 and irq_n = 1.
REQ-042 Two bytes 0x11 and 0x22 with no read between -> macro off: OVRN = 1 and RDR = 0x11; status read then data read clears OVRN. Macro on: both bytes are read back in order and OVRN stays 0.
REQ-043 Stop bit driven 0 for byte 0x7E -> FE = 1, RDRF = 1, RDR = 0x7E; the next data read clears FE.
REQ-044 Glitch low on rxd for 4 pulses at /16 -> no RDRF and the FSM is back in R_IDLE; a CR = 0x03 write mid-frame returns txd = 1, TDRE = 1 and clears the status flags.
REQ-045 Assert mcu_rst_n = 0 asynchronously mid-transmit -> txd = 1 with no clock edge and all status flags at their REQ-034 values.
